// File: rtl/darom_feeder.sv
// Sample feeder for a distributed-arithmetic FIR engine: a small input FIFO drains
// into a three-tap delay line once per frame, and the taps stay stable for the whole frame.
module darom_feeder #(
    parameter int W         = 3,
    parameter int FRAME     = 5,
    parameter int DEPTH     = 4,
    parameter int ZERO_FILL = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] x_in,
    input  logic         x_valid,
    output logic         x_ready,
    output logic [W-1:0] x_in0,
    output logic [W-1:0] x_in1,
    output logic [W-1:0] x_in2,
    output logic         frame_start,
    output logic         taps_valid,
    output logic         underrun
);

    localparam int FCW = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam logic [FCW-1:0] FLAST = FCW'(FRAME - 1);

    logic [FCW-1:0] fcnt;
    logic [W-1:0]   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic [1:0]     vcnt;
    logic           advance;
    logic           wr_en;
    logic           pop;
    logic           full;
    logic           empty;

    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        advance = (fcnt == FLAST);
        // x_ready is plain "not full": a pop in the same cycle never frees a slot early
        wr_en   = x_valid && x_ready;
        pop     = advance && !empty;
    end

    assign x_ready     = reset_n && !full;
    assign frame_start = !reset_n || (fcnt == '0);
    assign taps_valid  = (vcnt == 2'd3);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= x_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fcnt     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            x_in0    <= '0;
            x_in1    <= '0;
            x_in2    <= '0;
            vcnt     <= '0;
            underrun <= 1'b0;
        end else begin
            fcnt <= advance ? '0 : fcnt + FCW'(1);

            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // An empty FIFO at the advance never forwards a same-cycle write
            if (advance) begin
                if (pop) begin
                    x_in2 <= x_in1;
                    x_in1 <= x_in0;
                    x_in0 <= mem[rd_ptr];
                    if (vcnt != 2'd3) begin
                        vcnt <= vcnt + 2'd1;
                    end
                end else begin
                    underrun <= 1'b1;
                    if (ZERO_FILL != 0) begin
                        x_in2 <= x_in1;
                        x_in1 <= x_in0;
                        x_in0 <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_darom_feeder.sv
// Directed bench for darom_feeder: a zero-fill and a hold instance share one stimulus;
// a per-cycle monitor checks frame_start cadence and tap stability.
module tb_darom_feeder;

    localparam int W     = 3;
    localparam int FRAME = 5;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] x_in;
    logic         x_valid;

    logic         zf_ready, zf_fs, zf_tv, zf_ur;
    logic [W-1:0] zf_t0, zf_t1, zf_t2;
    logic         hd_ready, hd_fs, hd_tv, hd_ur;
    logic [W-1:0] hd_t0, hd_t1, hd_t2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    darom_feeder #(.W(W), .FRAME(FRAME), .DEPTH(4), .ZERO_FILL(1)) u_zf (
        .clk(clk), .reset_n(reset_n), .x_in(x_in), .x_valid(x_valid), .x_ready(zf_ready),
        .x_in0(zf_t0), .x_in1(zf_t1), .x_in2(zf_t2),
        .frame_start(zf_fs), .taps_valid(zf_tv), .underrun(zf_ur)
    );

    darom_feeder #(.W(W), .FRAME(FRAME), .DEPTH(4), .ZERO_FILL(0)) u_hd (
        .clk(clk), .reset_n(reset_n), .x_in(x_in), .x_valid(x_valid), .x_ready(hd_ready),
        .x_in0(hd_t0), .x_in1(hd_t1), .x_in2(hd_t2),
        .frame_start(hd_fs), .taps_valid(hd_tv), .underrun(hd_ur)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zf(input string tag, input int a, input int b, input int c);
        chk({tag, ".zf.x_in0"}, 32'(zf_t0), 32'(a));
        chk({tag, ".zf.x_in1"}, 32'(zf_t1), 32'(b));
        chk({tag, ".zf.x_in2"}, 32'(zf_t2), 32'(c));
    endtask

    task automatic chk_hd(input string tag, input int a, input int b, input int c);
        chk({tag, ".hd.x_in0"}, 32'(hd_t0), 32'(a));
        chk({tag, ".hd.x_in1"}, 32'(hd_t1), 32'(b));
        chk({tag, ".hd.x_in2"}, 32'(hd_t2), 32'(c));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Independent frame-phase model
    int   exp_ph  = 0;
    logic started = 1'b0;
    logic [W-1:0] p_zf0, p_zf1, p_zf2, p_hd0, p_hd1, p_hd2;

    always @(posedge clk) begin
        started <= 1'b1;
        if (!reset_n) exp_ph <= 0;
        else          exp_ph <= (exp_ph == FRAME - 1) ? 0 : exp_ph + 1;
    end

    always @(negedge clk) begin
        #1;
        if (started) begin
            chk("mon.frame_start.zf", 32'(zf_fs), 32'(!reset_n || exp_ph == 0));
            chk("mon.frame_start.hd", 32'(hd_fs), 32'(!reset_n || exp_ph == 0));
            if (!reset_n) chk("mon.x_ready_in_reset", 32'(zf_ready), 32'd0);
            if (exp_ph != 0) begin
                chk("mon.stable.zf", 32'({zf_t0, zf_t1, zf_t2}), 32'({p_zf0, p_zf1, p_zf2}));
                chk("mon.stable.hd", 32'({hd_t0, hd_t1, hd_t2}), 32'({p_hd0, p_hd1, p_hd2}));
            end
            {p_zf0, p_zf1, p_zf2} = {zf_t0, zf_t1, zf_t2};
            {p_hd0, p_hd1, p_hd2} = {hd_t0, hd_t1, hd_t2};
        end
    end

    initial begin
        reset_n = 1'b0;
        x_valid = 1'b0;
        x_in    = '0;

        tick(2);
        chk_zf("rst", 0, 0, 0);
        chk_hd("rst", 0, 0, 0);
        chk("rst.taps_valid", 32'(zf_tv), 32'd0);
        chk("rst.underrun", 32'(zf_ur), 32'd0);
        chk("rst.x_ready", 32'(zf_ready), 32'd0);
        chk("rst.frame_start", 32'(zf_fs), 32'd1);

        reset_n = 1'b1; x_valid = 1'b1; x_in = 3'd1;
        #1;
        chk("rel.x_ready", 32'(zf_ready), 32'd1);
        chk("rel.frame_start", 32'(zf_fs), 32'd1);
        tick(1); x_in = 3'd2;
        tick(1); x_in = 3'd3;
        tick(1); chk("fill.ready3", 32'(zf_ready), 32'd1); x_in = 3'b111;
        tick(1); chk("fill.full4", 32'(zf_ready), 32'd0); x_valid = 1'b0;
        tick(1);
        chk_zf("adv1", 1, 0, 0);
        chk("adv1.taps_valid", 32'(zf_tv), 32'd0);
        chk("adv1.frame_start", 32'(zf_fs), 32'd1);
        chk("adv1.x_ready", 32'(zf_ready), 32'd1);
        tick(10);
        chk_zf("adv3", 3, 2, 1);
        chk("adv3.taps_valid", 32'(zf_tv), 32'd1);
        tick(5);
        chk_zf("adv4", 7, 3, 2);

        // Backpressure: four writes between advances, fifth waits for the pop
        x_valid = 1'b1; x_in = 3'd4;
        tick(1); x_in = 3'd5;
        tick(1); x_in = 3'd6;
        tick(1); chk("bp.ready_before4", 32'(zf_ready), 32'd1); x_in = 3'd1;
        tick(1); chk("bp.ready_after4", 32'(zf_ready), 32'd0); x_in = 3'd2;
        tick(1);
        chk("bp.ready_after_pop", 32'(zf_ready), 32'd1);
        chk_zf("bp.adv5", 4, 7, 3);
        tick(1); chk("bp.refull", 32'(zf_ready), 32'd0); x_valid = 1'b0;
        tick(4); chk_zf("bp.adv6", 5, 4, 7);

        // Write lands on the advance with two entries queued
        tick(9); chk_zf("sim.pre", 6, 5, 4); x_valid = 1'b1; x_in = 3'd3;
        tick(1); x_valid = 1'b0; chk_zf("sim.adv8", 1, 6, 5);
        tick(5); chk_zf("sim.adv9", 2, 1, 6);
        tick(5);
        chk_zf("sim.adv10", 3, 2, 1);
        chk("pre_starve.underrun.zf", 32'(zf_ur), 32'd0);
        chk("pre_starve.underrun.hd", 32'(hd_ur), 32'd0);

        // Starved advance; the same-cycle write must not bypass
        tick(4); x_valid = 1'b1; x_in = 3'd5;
        tick(1); x_valid = 1'b0;
        chk_zf("starve", 0, 3, 2);
        chk_hd("starve", 3, 2, 1);
        chk("starve.underrun.zf", 32'(zf_ur), 32'd1);
        chk("starve.underrun.hd", 32'(hd_ur), 32'd1);
        chk("starve.taps_valid.zf", 32'(zf_tv), 32'd1);
        chk("starve.taps_valid.hd", 32'(hd_tv), 32'd1);
        tick(5);
        chk_zf("nobypass", 5, 0, 3);
        chk_hd("nobypass", 5, 3, 2);
        chk("nobypass.underrun_sticky", 32'(zf_ur), 32'd1);

        // Mid-frame reset with three entries queued
        x_valid = 1'b1; x_in = 3'd1;
        tick(1); x_in = 3'd2;
        tick(1); x_in = 3'd3;
        tick(1); x_valid = 1'b0; reset_n = 1'b0;
        tick(1);
        chk_zf("mrst", 0, 0, 0);
        chk_hd("mrst", 0, 0, 0);
        chk("mrst.underrun", 32'(zf_ur), 32'd0);
        chk("mrst.taps_valid", 32'(zf_tv), 32'd0);
        chk("mrst.x_ready", 32'(zf_ready), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("mrst.rel.x_ready", 32'(zf_ready), 32'd1);
        tick(5);
        chk_zf("mrst.empty", 0, 0, 0);
        chk("mrst.empty.underrun", 32'(zf_ur), 32'd1);
        chk("mrst.empty.taps_valid", 32'(zf_tv), 32'd0);
        x_valid = 1'b1; x_in = 3'b110;
        tick(1); x_in = 3'd2;
        tick(1); x_valid = 1'b0;
        tick(8);
        chk_zf("zf_nocount", 2, 6, 0);
        chk_hd("zf_nocount", 2, 6, 0);
        chk("zf_nocount.taps_valid.zf", 32'(zf_tv), 32'd0);
        chk("zf_nocount.taps_valid.hd", 32'(hd_tv), 32'd0);

        tick(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/darom_feeder.md
DAROM_FEEDER -- requirements
Module: darom_feeder

Interface
REQ-001 Parameter W, default 3: sample width in bits, two's complement.
REQ-002 Parameter FRAME, default 5: clock cycles per DA frame (one load cycle plus W+1 processing cycles of the downstream engine).
REQ-003 Parameter DEPTH, default 4: input FIFO entries, a power of two, at least 2.
REQ-004 Parameter ZERO_FILL, default 1: 1 shifts in zero on starvation; 0 holds the taps.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 x_in  input  W  incoming sample.
REQ-008 x_valid  input  1  x_in is valid this cycle.
REQ-009 x_ready  output  1  FIFO can accept a sample this cycle.
REQ-010 x_in0, x_in1, x_in2  output  W each  tap outputs to the DA engine; x_in0 is the newest.
REQ-011 frame_start  output  1  high in the cycle where fcnt==0 (the engine load cycle).
REQ-012 taps_valid  output  1  three real samples have entered the taps.
REQ-013 underrun  output  1  sticky flag; set when a frame advance finds the FIFO empty.

Function
REQ-014 The frame counter fcnt SHALL count 0..FRAME-1, wrap to 0, and run continuously out of reset.
REQ-015 A frame advance SHALL occur on the edge where fcnt goes from FRAME-1 to 0; the taps SHALL change only at that edge and stay stable for the full frame, including the frame_start cycle.
REQ-016 x_ready SHALL equal "FIFO not full" and SHALL NOT depend on a same-cycle read (no full-FIFO pass-through).
REQ-017 A write SHALL occur when x_valid && x_ready; x_in SHALL be stored in FIFO order.
REQ-018 On a frame advance with the FIFO non-empty, the taps SHALL update x_in2<=x_in1, x_in1<=x_in0, x_in0<=FIFO head, and the FIFO SHALL pop one entry.
REQ-019 With the FIFO empty at the advance, there SHALL be no bypass: a sample written in the same cycle is consumed at the next advance.
REQ-020 On a starved advance with ZERO_FILL=1, the taps SHALL shift with x_in0<=0; with ZERO_FILL=0, the taps SHALL hold.
REQ-021 In both starvation cases, underrun SHALL be set and held until reset.
REQ-022 When the FIFO is non-empty and not full, a simultaneous write and pop SHALL leave the occupancy unchanged.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-024 A saturating counter of popped samples, range 0..3, SHALL drive taps_valid, which is high when the count is 3; zero-filled shifts SHALL NOT increment it.
REQ-025 Taps SHALL be plain registers: no arithmetic, and the sign is carried unchanged.

Reset
REQ-026 While reset_n is low at a clock edge, the block SHALL set fcnt=0, empty the FIFO, zero the taps, and clear taps_valid and underrun.
REQ-027 While reset_n is low, x_ready SHALL be 0 and frame_start SHALL be 1.
REQ-028 Reset asserted mid-frame or with the FIFO partly full SHALL discard all contents, with no partial shift.
REQ-029 In the first cycle after release, fcnt SHALL be 0 and x_ready SHALL be 1.

Verification
REQ-030 Fill and shift: with defaults, write samples 1, 2, 3, then 3'b111 before the first advance -> after three advances the taps are x_in0=3, x_in1=2, x_in2=1 and taps_valid=1; after the fourth advance the taps are 7, 3, 2.
REQ-031 Backpressure: hold x_valid high with no advance for 4 cycles -> x_ready drops after the 4th accepted write; the 5th sample is not accepted until the pop at the next advance.
REQ-032 Starvation: with ZERO_FILL=1 and the taps holding 3, 2, 1, an advance with the FIFO empty -> taps become 0, 3, 2, underrun=1, taps_valid stays 1; with ZERO_FILL=0 the taps stay 3, 2, 1.
REQ-033 Simultaneous events: the FIFO holds 2 entries and a write lands on the advance cycle -> occupancy stays 2 and the order is preserved.
REQ-034 Stability: check every cycle that the taps change only on the FRAME-1 -> 0 edge and that frame_start is high exactly once per 5 cycles.
REQ-035 Mid-operation reset: pulse reset_n low for 1 cycle with fcnt=3 and the FIFO holding 3 entries -> next cycle all taps are 0, fcnt=0, the FIFO is empty, and underrun=0.
